kpyd_emulator: RTL and testbench

- Synthesizable 4x4 keypad model: the "key side" of the keypad scan interface.
- Accepts 4-bit symbols over a valid/ready handshake and queues them.
- Replays each symbol as a physical press: bounce, hold, bounce, release gap. Drives active-low row lines in response to the active-low column strobes from the scanner.
- Used for on-board loopback and regression of the debounced keypad scanner without a physical keypad.

---
 rtl/kpyd_pkg.sv | 43 ++++
 rtl/kpyd_sym_fifo.sv | 58 +++++
 rtl/kpyd_emulator.sv | 164 ++++++++++++++++
 tb/tb_kpyd_emulator.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kpyd_pkg.sv
// Shared types and key map for the keypad emulator.
// The symbol->position table mirrors the one used by the keypad scanner.
package kpyd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B_PRESS,
    ST_HOLD,
    ST_B_REL,
    ST_GAP
  } kpyd_state_e;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } kpyd_pos_t;

  localparam logic [3:0] KPYD_IDLE_ROW = 4'b1111;

  function automatic kpyd_pos_t kpyd_key_pos(input logic [3:0] sym);
    kpyd_pos_t pos;
    case (sym)
      4'hD: pos = '{col: 2'd0, row: 2'd0};
      4'hC: pos = '{col: 2'd0, row: 2'd1};
      4'hB: pos = '{col: 2'd0, row: 2'd2};
      4'hA: pos = '{col: 2'd0, row: 2'd3};
      4'hE: pos = '{col: 2'd1, row: 2'd0};
      4'h9: pos = '{col: 2'd1, row: 2'd1};
      4'h6: pos = '{col: 2'd1, row: 2'd2};
      4'h3: pos = '{col: 2'd1, row: 2'd3};
      4'hF: pos = '{col: 2'd2, row: 2'd0};
      4'h8: pos = '{col: 2'd2, row: 2'd1};
      4'h5: pos = '{col: 2'd2, row: 2'd2};
      4'h2: pos = '{col: 2'd2, row: 2'd3};
      4'h0: pos = '{col: 2'd3, row: 2'd0};
      4'h7: pos = '{col: 2'd3, row: 2'd1};
      4'h4: pos = '{col: 2'd3, row: 2'd2};
      default: pos = '{col: 2'd3, row: 2'd3};  // 4'h1
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/kpyd_sym_fifo.sv
// Small symbol FIFO with first-word fall-through read, so the head is
// visible on dout_o in the same cycle the consumer pops it.
module kpyd_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Full is decoded from the registered count, so a pop cannot free a slot
  // for a push in the same cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/kpyd_emulator.sv
// Key side of a 4x4 keypad: queued symbols are replayed as physical presses
// (bounce, hold, bounce, gap) and answer the scanner's column strobes.
module kpyd_emulator
  import kpyd_pkg::*;
#(
  parameter int         DEPTH         = 4,
  parameter int         HOLD_CYCLES   = 1000,
  parameter int         BOUNCE_CYCLES = 64,
  parameter int         GAP_CYCLES    = 1000,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [3:0] symbol_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [3:0] kpyd_col_i,
  output logic [3:0] kpyd_row_o,
  output logic       pressed_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > BOUNCE_CYCLES)
                         ? ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES)
                         : ((BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYCLES);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  kpyd_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  kpyd_pos_t     key_q, key_d;
  logic          pressed_q, pressed_d;
  logic          done_q, done_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [3:0]    fifo_dout;

  kpyd_sym_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (valid_i),
    .din_i    (symbol_i),
    .pop_i    (fifo_pop),
    .dout_o   (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // x^8 + x^6 + x^5 + x^4 + 1: maximal length, so a nonzero seed never reaches zero.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          key_d    = kpyd_key_pos(fifo_dout);
          if (BOUNCE_CYCLES == 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_B_PRESS;
            cnt_d   = BOUNCE_LD;
          end
        end
      end
      ST_B_PRESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          if (BOUNCE_CYCLES == 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_B_REL;
            cnt_d   = BOUNCE_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_B_REL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Contact and done are derived from the next state so the registered
  // outputs line up with the state register rather than trailing it.
  always_comb begin
    pressed_d = 1'b0;
    case (state_d)
      ST_B_PRESS, ST_B_REL: pressed_d = lfsr_d[0];
      ST_HOLD:              pressed_d = 1'b1;
      default:              pressed_d = 1'b0;
    endcase
    done_d = (state_d == ST_GAP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      key_q     <= '0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
      done_q    <= done_d;
    end
  end

  // Only the latched key's column matters; other strobe bits are ignored.
  assign kpyd_row_o = (pressed_q && !kpyd_col_i[key_q.col])
                    ? ~(4'b0001 << key_q.row)
                    : KPYD_IDLE_ROW;

  assign ready_o   = !fifo_full;
  assign pressed_o = pressed_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_kpyd_emulator.sv
// Bench for kpyd_emulator: two instances (no-bounce and bouncing) checked every
// cycle against a timeline model, plus a behavioural scanner for loopback.
module tb_kpyd_emulator;

  localparam int D   = 4;
  localparam int B0  = 0;
  localparam int H0  = 8;
  localparam int G0  = 4;
  localparam int B1  = 16;
  localparam int H1  = 64;
  localparam int G1  = 40;
  localparam int DEB = 6;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic [3:0] col;
  logic [3:0] sym0, sym1, row0, row1;
  logic       vld0, vld1, rdy0, rdy1, pr0, pr1, by0, by1, dn0, dn1;

  always #5 clk_i = ~clk_i;

  kpyd_emulator #(
    .DEPTH(D), .HOLD_CYCLES(H0), .BOUNCE_CYCLES(B0), .GAP_CYCLES(G0), .LFSR_SEED(8'hA5)
  ) u_nb (
    .clk_i(clk_i), .reset_ni(reset_ni), .symbol_i(sym0), .valid_i(vld0), .ready_o(rdy0),
    .kpyd_col_i(col), .kpyd_row_o(row0), .pressed_o(pr0), .busy_o(by0), .done_o(dn0)
  );

  kpyd_emulator #(
    .DEPTH(D), .HOLD_CYCLES(H1), .BOUNCE_CYCLES(B1), .GAP_CYCLES(G1), .LFSR_SEED(8'hA5)
  ) u_b (
    .clk_i(clk_i), .reset_ni(reset_ni), .symbol_i(sym1), .valid_i(vld1), .ready_o(rdy1),
    .kpyd_col_i(col), .kpyd_row_o(row1), .pressed_o(pr1), .busy_o(by1), .done_o(dn1)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int bnc [2] = '{B0, B1};
  int hld [2] = '{H0, H1};
  int gp  [2] = '{G0, G1};
  logic [3:0] keytab [4][4] = '{'{4'hD, 4'hC, 4'hB, 4'hA}, '{4'hE, 4'h9, 4'h6, 4'h3},
                                '{4'hF, 4'h8, 4'h5, 4'h2}, '{4'h0, 4'h7, 4'h4, 4'h1}};
  logic [3:0] one4 = 4'b0001;

  // Reference model: a circular queue plus "position t within the current key".
  logic [3:0] mq [2][8];
  int         mhd [2];
  int         mcnt [2];
  int         mt [2];
  bit         mact [2];
  bit         macc [2];
  logic [3:0] mcur [2];
  logic [7:0] mlfsr;

  int   dcnt [2] = '{0, 0};
  int   acc_cyc, rise_cyc, done_cyc, togp, togr;
  bit   prev0, prev1;
  bit   col_rand, scan_mode;
  logic [3:0] col_fix;
  int   sc_k, sc_seen, sc_prev, sc_n, nrep;
  logic [3:0] rep [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhd[i] = 0; mcnt[i] = 0; mt[i] = 0; mact[i] = 0; macc[i] = 0;
    end
    mlfsr = 8'hA5;
  endtask

  task automatic model_edge(input int i);
    bit v;
    logic [3:0] s;
    bit acc;
    v = (i == 0) ? vld0 : vld1;
    s = (i == 0) ? sym0 : sym1;
    acc = v && (mcnt[i] < D);
    if (mact[i]) begin
      mt[i]++;
      if (mt[i] == 2 * bnc[i] + hld[i] + gp[i]) mact[i] = 0;
    end else if (mcnt[i] > 0) begin
      mcur[i] = mq[i][mhd[i]];
      mhd[i] = (mhd[i] + 1) % 8;
      mcnt[i]--;
      mact[i] = 1;
      mt[i] = 0;
    end
    if (acc) begin
      mq[i][(mhd[i] + mcnt[i]) % 8] = s;
      mcnt[i]++;
      if (i == 0) acc_cyc = cyc;
    end
    macc[i] = acc;
  endtask

  function automatic bit exp_pressed(input int i);
    int t;
    t = mt[i];
    if (!mact[i]) return 1'b0;
    if (t < bnc[i]) return mlfsr[0];
    if (t < bnc[i] + hld[i]) return 1'b1;
    if (t < 2 * bnc[i] + hld[i]) return mlfsr[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(input int i);
    int c, r;
    c = 0; r = 0;
    if (!exp_pressed(i)) return 4'hF;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        if (keytab[a][b] == mcur[i]) begin c = a; r = b; end
    if (col[c]) return 4'hF;
    return ~(one4 << r);
  endfunction

  task automatic step();
    @(posedge clk_i);
    cyc++;
    if (!reset_ni) begin
      model_reset();
    end else begin
      model_edge(0);
      model_edge(1);
      mlfsr = {mlfsr[6:0], ^(mlfsr & 8'hB8)};
    end
    #1;
    if (scan_mode) begin
      if (row1 != 4'hF)
        for (int r = 0; r < 4; r++) if (!row1[r]) sc_seen = int'(keytab[sc_k][r]);
      if (sc_k == 3) begin
        if (sc_seen == sc_prev) sc_n++;
        else begin sc_prev = sc_seen; sc_n = 1; end
        if (sc_n == DEB && sc_prev >= 0 && nrep < 8) begin
          rep[nrep] = sc_prev[3:0];
          nrep++;
        end
        sc_seen = -1;
      end
      sc_k = (sc_k + 1) % 4;
      col = ~(one4 << sc_k);
    end else if (col_rand) begin
      col = 4'($urandom);
    end else begin
      col = col_fix;
    end
    #1;
    check_eq("nb_pressed", pr0, exp_pressed(0));
    check_eq("nb_done", dn0, mact[0] && mt[0] == H0 + G0 - 1);
    check_eq("nb_busy", by0, mact[0] || mcnt[0] > 0);
    check_eq("nb_ready", rdy0, mcnt[0] < D);
    check_eq("nb_row", row0, exp_row(0));
    check_eq("b_pressed", pr1, exp_pressed(1));
    check_eq("b_done", dn1, mact[1] && mt[1] == 2 * B1 + H1 + G1 - 1);
    check_eq("b_busy", by1, mact[1] || mcnt[1] > 0);
    check_eq("b_ready", rdy1, mcnt[1] < D);
    check_eq("b_row", row1, exp_row(1));
    check_eq("b_one_row", $countones(~row1) <= 1, 1);
    if (mact[1] && mt[1] < B1 && pr1 != prev1) togp++;
    if (mact[1] && mt[1] >= B1 + H1 && mt[1] < 2 * B1 + H1 && pr1 != prev1) togr++;
    if (pr0 && !prev0) rise_cyc = cyc;
    if (dn0) done_cyc = cyc;
    prev0 = pr0;
    prev1 = pr1;
    dcnt[0] += int'(dn0);
    dcnt[1] += int'(dn1);
  endtask

  task automatic push(input int i, input logic [3:0] s);
    int n;
    n = 0;
    if (i == 0) begin sym0 = s; vld0 = 1; end
    else        begin sym1 = s; vld1 = 1; end
    do begin step(); n++; end while (!macc[i] && n < 2000);
    if (!macc[i]) check_eq("push_timeout", 0, 1);
    if (i == 0) vld0 = 0; else vld1 = 0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while ((mact[i] || mcnt[i] > 0) && n < budget) begin step(); n++; end
    if (mact[i] || mcnt[i] > 0) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic press_check(input logic [3:0] s, input logic [3:0] c, input logic [3:0] r);
    int n;
    n = 0;
    col_rand = 0;
    col_fix = c;
    push(0, s);
    while (!exp_pressed(0) && n < 50) begin step(); n++; end
    check_eq("map_row", row0, r);
    wait_idle(0, 100);
  endtask

  initial begin
    int d0, idx, n;
    logic [3:0] bp [6];
    bp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    reset_ni = 1; vld0 = 1; vld1 = 1; sym0 = 4'h3; sym1 = 4'h3;
    col = 4'b0000; col_fix = 4'b0000; col_rand = 0; scan_mode = 0;
    togp = 0; togr = 0; prev0 = 0; prev1 = 0; acc_cyc = 0; rise_cyc = 0; done_cyc = 0;
    sc_k = 0; sc_seen = -1; sc_prev = -1; sc_n = 0; nrep = 0;
    model_reset();
    #1 reset_ni = 0;
    #2;
    check_eq("rst_row0", row0, 4'hF);
    check_eq("rst_row1", row1, 4'hF);
    check_eq("rst_ready", rdy0, 1);
    check_eq("rst_pressed", pr0, 0);
    check_eq("rst_busy", by0, 0);
    check_eq("rst_done", dn0, 0);
    repeat (3) step();
    vld0 = 0; vld1 = 0;
    reset_ni = 1;
    step();
    check_eq("rst_nopush", by0, 0);

    // No-bounce press of '5' on column 2.
    d0 = dcnt[0];
    col_fix = 4'b1011;
    push(0, 4'h5);
    repeat (5) step();
    check_eq("hold_row", row0, 4'b1011);
    col_fix = 4'b1110;
    step();
    check_eq("other_col_row", row0, 4'hF);
    wait_idle(0, 100);
    check_eq("rise_latency", rise_cyc - acc_cyc, 1);
    // done sits in the last GAP cycle: HOLD+GAP-1 cycles after the rise
    check_eq("done_latency", done_cyc - rise_cyc, H0 + G0 - 1);
    check_eq("done_count", dcnt[0] - d0, 1);

    press_check(4'hA, 4'b1110, 4'b0111);
    press_check(4'h0, 4'b0111, 4'b1110);
    press_check(4'hE, 4'b1101, 4'b1110);

    // Full symbol sweep with random strobes.
    d0 = dcnt[0];
    col_rand = 1;
    for (int s = 0; s < 16; s++) push(0, 4'(s));
    wait_idle(0, 1000);
    check_eq("sweep_dones", dcnt[0] - d0, 16);

    // Backpressure: six back-to-back offers.
    d0 = dcnt[0];
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      vld0 = 1; sym0 = bp[idx];
      step();
      if (macc[0]) idx++;
    end
    check_eq("bp_accepted", idx, 5);
    check_eq("bp_ready_low", rdy0, 0);
    n = 0;
    while (idx < 6 && n < 200) begin
      sym0 = bp[idx];
      step();
      if (macc[0]) idx++;
      n++;
    end
    vld0 = 0;
    check_eq("bp_all_in", idx, 6);
    wait_idle(0, 500);
    check_eq("bp_dones", dcnt[0] - d0, 6);

    // Bouncing key.
    togp = 0; togr = 0;
    push(1, 4'h7);
    wait_idle(1, 500);
    check_eq("bounce_press_toggles", togp >= 2, 1);
    check_eq("bounce_rel_toggles", togr >= 2, 1);

    // Reset in the middle of HOLD with keys queued.
    push(0, 4'h3);
    push(0, 4'h6);
    push(0, 4'h9);
    n = 0;
    while (!(mact[0] && mt[0] >= 2 && mt[0] < H0) && n < 100) begin step(); n++; end
    col_rand = 0; col_fix = 4'b0000; col = 4'b0000;
    #1 reset_ni = 0;
    #1;
    check_eq("midrst_row", row0, 4'hF);
    check_eq("midrst_busy", by0, 0);
    check_eq("midrst_pressed", pr0, 0);
    model_reset();
    repeat (2) step();
    reset_ni = 1;
    d0 = dcnt[0];
    col_rand = 1;
    push(0, 4'h1);
    wait_idle(0, 100);
    check_eq("postrst_dones", dcnt[0] - d0, 1);

    // Loopback through a behavioural debounced scanner.
    scan_mode = 1; sc_k = 0; col = ~one4; sc_seen = -1; sc_prev = -1; sc_n = 0; nrep = 0;
    push(1, 4'h1);
    push(1, 4'h2);
    push(1, 4'hE);
    wait_idle(1, 2000);
    repeat (40) step();
    check_eq("loop_count", nrep, 3);
    check_eq("loop_sym0", rep[0], 4'h1);
    check_eq("loop_sym1", rep[1], 4'h2);
    check_eq("loop_sym2", rep[2], 4'hE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
